// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants, M-extension encodings and divider state type
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_e;
  function automatic logic is_signed_op(logic [1:0] op);
    return !(op == F3_DIVU[1:0] || op == F3_REMU[1:0]);
  endfunction
  function automatic logic is_rem_op(logic [1:0] op);
    return !(op == F3_DIV[1:0] || op == F3_DIVU[1:0]);
  endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per clock
module div_unit import rv32_pkg::*; #(
  parameter int XLEN = rv32_pkg::XLEN,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_addr_out
);
  localparam int CW = $clog2(XLEN) + 1;
  div_state_e state;
  logic [1:0] op_q;
  logic [4:0] rd_q;
  logic [XLEN-1:0] quo, rem, dvs;
  logic q_neg, r_neg;
  logic [CW-1:0] cnt;
  logic sgn, by_zero, ovf, special, ge;
  logic [XLEN-1:0] a_abs, b_abs, spec_res, quo_nx, rem_nx, res;
  logic [XLEN:0] rem_sh;
  always_comb begin
    sgn = is_signed_op(op);
    a_abs = (sgn && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
    b_abs = (sgn && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
    by_zero = rs2_data == '0;
    ovf = sgn && rs1_data == INT_MIN && rs2_data == ALL_ONES;
    special = FAST_SPECIAL && (by_zero || ovf);
    spec_res = by_zero ? (is_rem_op(op) ? rs1_data : ALL_ONES) : (is_rem_op(op) ? '0 : INT_MIN);
    rem_sh = {rem, quo[XLEN-1]};
    ge = rem_sh >= {1'b0, dvs};
    rem_nx = ge ? rem_sh[XLEN-1:0] - dvs : rem_sh[XLEN-1:0];
    quo_nx = {quo[XLEN-2:0], ge};
    res = is_rem_op(op_q) ? (r_neg ? -rem_nx : rem_nx) : (q_neg ? -quo_nx : quo_nx);
  end
  assign busy = state != DIV_IDLE;
  // divide-by-zero keeps the all-ones quotient positive so the iterative path matches the fast path
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      op_q <= '0;
      rd_q <= '0;
      quo <= '0;
      rem <= '0;
      dvs <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      cnt <= '0;
      done <= 1'b0;
      result <= '0;
      rd_addr_out <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
      done <= 1'b0;
    end else if (state == DIV_IDLE) begin
      done <= 1'b0;
      if (start) begin
        op_q <= op;
        rd_q <= rd_addr_in;
        quo <= a_abs;
        dvs <= b_abs;
        rem <= '0;
        cnt <= CW'(XLEN);
        q_neg <= sgn && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]) && !by_zero;
        r_neg <= sgn && rs1_data[XLEN-1];
        state <= special ? DIV_DONE : DIV_CALC;
        if (special) begin
          done <= 1'b1;
          result <= spec_res;
          rd_addr_out <= rd_addr_in;
        end
      end
    end else if (state == DIV_CALC) begin
      quo <= quo_nx;
      rem <= rem_nx;
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        state <= DIV_DONE;
        done <= 1'b1;
        result <= res;
        rd_addr_out <= rd_q;
      end
    end else begin
      state <= DIV_IDLE;
      done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench driving fast-special and full-latency divider instances in lockstep
module tb_div_unit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0] op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0] rd_in = '0;
  logic busy_f, done_f, busy_s, done_s;
  logic [31:0] res_f, res_s;
  logic [4:0] rd_f, rd_s;
  int checks = 0, passed = 0;
  typedef struct {logic [31:0] res; logic [4:0] rd; int lat;} exp_t;
  exp_t q_f[$], q_s[$];
  logic [31:0] last_res = '0;
  logic [4:0] last_rd = '0;
  always #5 clk = ~clk;
  div_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_f (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_data(rs1), .rs2_data(rs2),
    .rd_addr_in(rd_in), .flush(flush), .busy(busy_f), .done(done_f), .result(res_f), .rd_addr_out(rd_f));
  div_unit #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1_data(rs1), .rs2_data(rs2),
    .rd_addr_in(rd_in), .flush(flush), .busy(busy_s), .done(done_s), .result(res_s), .rd_addr_out(rd_s));
  function automatic logic [31:0] ref_div(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    if (!o[0]) return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    return o[1] ? a % b : a / b;
  endfunction
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] expv, input bit poke);
    exp_t e, g;
    bit spec, gf, gs;
    int bf, bs;
    spec = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    gf = 0; gs = 0; bf = 0; bs = 0;
    e.res = expv; e.rd = rd; e.lat = spec ? 1 : 33;
    q_f.push_back(e);
    e.lat = 33;
    q_s.push_back(e);
    @(negedge clk);
    start = 1; op = o; rs1 = a; rs2 = b; rd_in = rd;
    @(posedge clk);
    #1 start = 0; rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom); op = 2'($urandom);
    for (int n = 1; n <= 36; n++) begin
      @(negedge clk);
      bf += int'(busy_f);
      bs += int'(busy_s);
      if (done_f) begin
        checks++;
        if (gf || q_f.size() == 0) $display("FAIL fast_unexpected_done cycle=%0d", n);
        else begin
          passed++;
          gf = 1;
          g = q_f.pop_front();
          checks++;
          if (res_f !== g.res) $display("FAIL fast_result got=%h exp=%h", res_f, g.res); else passed++;
          checks++;
          if (rd_f !== g.rd) $display("FAIL fast_rd got=%0d exp=%0d", rd_f, g.rd); else passed++;
          checks++;
          if (n !== g.lat) $display("FAIL fast_latency got=%0d exp=%0d", n, g.lat); else passed++;
        end
      end
      if (done_s) begin
        checks++;
        if (gs || q_s.size() == 0) $display("FAIL slow_unexpected_done cycle=%0d", n);
        else begin
          passed++;
          gs = 1;
          g = q_s.pop_front();
          checks++;
          if (res_s !== g.res) $display("FAIL slow_result got=%h exp=%h", res_s, g.res); else passed++;
          checks++;
          if (rd_s !== g.rd) $display("FAIL slow_rd got=%0d exp=%0d", rd_s, g.rd); else passed++;
          checks++;
          if (n !== g.lat) $display("FAIL slow_latency got=%0d exp=%0d", n, g.lat); else passed++;
        end
      end
      if (poke && n == 5) begin
        start = 1; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom | 1; rd_in = 5'($urandom);
      end
      if (poke && n == 10) start = 0;
    end
    checks++;
    if (!gf || !gs) $display("FAIL done_timeout fast_seen=%0d slow_seen=%0d exp=1/1", gf, gs); else passed++;
    checks++;
    if (bf != (spec ? 1 : 33)) $display("FAIL fast_busy_cycles got=%0d exp=%0d", bf, spec ? 1 : 33); else passed++;
    checks++;
    if (bs != 33) $display("FAIL slow_busy_cycles got=%0d exp=33", bs); else passed++;
    last_res = expv;
    last_rd = rd;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_f, done_f, busy_s, done_s} !== 4'b0) $display("FAIL reset_flags got=%b exp=0000", {busy_f, done_f, busy_s, done_s}); else passed++;
    checks++;
    if ({res_f, res_s} !== 64'h0) $display("FAIL reset_result got=%h/%h exp=0", res_f, res_s); else passed++;
    checks++;
    if ({rd_f, rd_s} !== 10'h0) $display("FAIL reset_rd got=%0d/%0d exp=0", rd_f, rd_s); else passed++;
    rst_n = 1;
  endtask
  task automatic test_divu();
    run_op(2'b01, 32'd100, 32'd7, 5'd5, 32'h0000_000E, 0);
    run_op(2'b11, 32'd100, 32'd7, 5'd5, 32'h0000_0002, 0);
  endtask
  task automatic test_signed();
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 0);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd8, 32'h0000_0001, 0);
  endtask
  task automatic test_div_by_zero();
    run_op(2'b01, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 0);
    run_op(2'b11, 32'd5, 32'd0, 5'd10, 32'h0000_0005, 0);
    run_op(2'b00, 32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, 0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 0);
  endtask
  task automatic test_overflow();
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h0000_0000, 0);
    run_op(2'b01, 32'h8000_0000, 32'd1, 5'd15, 32'h8000_0000, 0);
  endtask
  task automatic test_flush();
    bit saw;
    saw = 0;
    @(negedge clk);
    start = 1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd20;
    @(posedge clk);
    #1 start = 0;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      saw |= done_f | done_s;
    end
    flush = 1;
    @(negedge clk);
    flush = 0;
    saw |= done_f | done_s;
    checks++;
    if (busy_f || busy_s) $display("FAIL flush_busy got=%b%b exp=00", busy_f, busy_s); else passed++;
    checks++;
    if (res_f !== last_res || res_s !== last_res) $display("FAIL flush_result got=%h/%h exp=%h", res_f, res_s, last_res); else passed++;
    checks++;
    if (rd_f !== last_rd || rd_s !== last_rd) $display("FAIL flush_rd got=%0d/%0d exp=%0d", rd_f, rd_s, last_rd); else passed++;
    start = 1; flush = 1; op = 2'b01; rs1 = 32'd50; rs2 = 32'd5; rd_in = 5'd22;
    @(negedge clk);
    start = 0; flush = 0;
    checks++;
    if (busy_f || busy_s) $display("FAIL flush_beats_start got=%b%b exp=00", busy_f, busy_s); else passed++;
    repeat (36) begin
      @(negedge clk);
      saw |= done_f | done_s;
    end
    checks++;
    if (saw) $display("FAIL flush_no_done got=1 exp=0"); else passed++;
    run_op(2'b01, 32'd9, 32'd3, 5'd16, 32'd3, 0);
  endtask
  task automatic test_start_while_busy();
    run_op(2'b01, 32'd100, 32'd7, 5'd3, 32'h0000_000E, 1);
  endtask
  task automatic test_random();
    logic [1:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      if (i % 2 == 1) b = -b;
      run_op(o, a, b, 5'(i + 24), ref_div(o, a, b), 0);
    end
  endtask
  task automatic test_reset_mid();
    bit saw;
    saw = 0;
    @(negedge clk);
    start = 1; op = 2'b01; rs1 = 32'd1000; rs2 = 32'd3; rd_in = 5'd21;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    rst_n = 0;
    #1;
    checks++;
    if ({busy_f, done_f, busy_s, done_s} !== 4'b0) $display("FAIL async_reset_flags got=%b exp=0000", {busy_f, done_f, busy_s, done_s}); else passed++;
    checks++;
    if ({res_f, res_s} !== 64'h0) $display("FAIL async_reset_result got=%h/%h exp=0", res_f, res_s); else passed++;
    checks++;
    if ({rd_f, rd_s} !== 10'h0) $display("FAIL async_reset_rd got=%0d/%0d exp=0", rd_f, rd_s); else passed++;
    @(negedge clk);
    rst_n = 1;
    repeat (40) begin
      @(negedge clk);
      saw |= done_f | done_s | busy_f | busy_s;
    end
    checks++;
    if (saw) $display("FAIL reset_no_resume got=1 exp=0"); else passed++;
    checks++;
    if (q_f.size() != 0 || q_s.size() != 0) $display("FAIL scoreboard_leftover got=%0d/%0d exp=0", q_f.size(), q_s.size()); else passed++;
  endtask
  initial begin
    test_reset();
    test_divu();
    test_signed();
    test_div_by_zero();
    test_overflow();
    test_flush();
    test_start_while_busy();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative RV32M divider in the EX stage, directly downstream of the register file.
- Consumes the rs1/rs2 read data and destination index for DIV/DIVU/REM/REMU.
- Produces a 32-bit result and rd index for the WB path back into the register file.
- Radix-2 restoring, one quotient bit per clock; pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width; counter width is clog2(XLEN)+1.
FAST_SPECIAL, 1, 1 = divide-by-zero and signed overflow finish in 1 cycle without iterating; 0 = they take the full latency with identical results.

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
op  input  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
rs1_data  input  XLEN  dividend, from register file read port 1
rs2_data  input  XLEN  divisor, from register file read port 2
rd_addr_in  input  5  destination register index
flush  input  1  synchronous abort (branch mispredict/trap)
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result/rd_addr_out valid
result  output  XLEN  quotient or remainder; held until the next accepted start
rd_addr_out  output  5  rd captured at start; held with result

Behaviour:
- Reset (async, rst_n=0): state IDLE, busy 0, done 0, result 0, rd_addr_out 0, counter 0, internal operand registers 0. Reset mid-operation discards the operation with no done pulse.
- Accept: on an edge with state IDLE, start=1, flush=0:
  - capture op, rd_addr_in, |rs1|, |rs2| (absolute values only for signed ops), quotient sign = s1^s2, remainder sign = s1;
  - clear remainder accumulator; load counter = XLEN.
  - Inputs are don't-care after capture.
- States:
  - IDLE -> CALC on accept.
  - IDLE -> DONE on accept when FAST_SPECIAL=1 and (divisor=0 or DIV/REM with 0x80000000 / 0xFFFFFFFF).
  - CALC: each edge shift {rem,quo} left 1; if rem_shifted >= divisor, subtract and set quotient LSB; decrement counter; -> DONE when the counter reaches 0 on that edge.
  - DONE: done=1, result valid; -> IDLE next edge.
- Latency:
  - normal: done high in the cycle after the XLEN-th CALC edge, i.e. sampled high on edge 33 after the accept edge (XLEN=32);
  - fast special: sampled high on edge 1 after the accept edge.
  - busy high from the accept edge until the edge leaving DONE.
- Result rules (RISC-V spec):
  - DIV/DIVU: quotient, negated when the quotient sign is set (signed ops only).
  - REM/REMU: remainder, negated when the remainder sign is set (signed ops only).
  - Divisor 0: DIV/DIVU = 0xFFFFFFFF, REM/REMU = dividend unchanged.
  - Signed overflow (0x80000000 / -1): DIV = 0x80000000, REM = 0.
  - The normal path must give the same special results when FAST_SPECIAL=0.
  - Absolute value of 0x80000000 is handled as unsigned 0x80000000; compare and subtract use XLEN+1 bits.
- result and rd_addr_out update only on the edge entering DONE; stable otherwise.
- start while busy: ignored, with no effect on the operation in flight.
- flush:
  - any state -> IDLE next edge; done is not asserted; result and rd_addr_out keep old values;
  - flush beats start on the same edge;
  - flush during the DONE cycle does not suppress the already-visible done pulse but still forces IDLE.
- No back-pressure: WB must accept the done pulse.

Decomposition:
- Shared package rv32_pkg:
  - XLEN;
  - M-extension funct3 encodings (DIV=3'b100, DIVU=3'b101, REM=3'b110, REMU=3'b111);
  - div state enum (IDLE, CALC, DONE);
  - constants INT_MIN=32'h80000000 and ALL_ONES.
- Optional sub-module udiv_core holds the unsigned shift/subtract datapath and counter; div_unit keeps the FSM, sign handling, special cases and handshake. A single flat module is acceptable within 120-400 lines.

Test Plan:
1. DIVU 100/7, rd=5 -> done on edge 33 after accept, result 0x0000000E, rd_addr_out 5, busy high 33 cycles. REMU same operands -> 0x00000002.
2. DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD. REM same -> 0xFFFFFFFF. DIV 7/0xFFFFFFFE -> 0xFFFFFFFD. REM 7/0xFFFFFFFE -> 0x00000001.
3. DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 0x00000005. With FAST_SPECIAL=1, done on edge 1 after accept; with FAST_SPECIAL=0, edge 33.
4. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0x00000000. DIVU 0x80000000/1 -> 0x80000000.
5. Start DIVU 1000/3, then flush on the 10th CALC edge -> busy low next cycle, no done, result unchanged. Immediate new start DIVU 9/3 -> result 3 on edge 33.
6. Assert start with new operands while busy -> original result unaffected. Pull rst_n low mid-CALC -> busy, done, result, rd_addr_out all 0 immediately (async), no later done pulse.
